// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS front end.
//   NOP           : instruction word shown on inst when no entry is valid
//   fetch_state_e : fetch FSM states (IDLE / BUSY / DRAIN)
//   fetch_entry_t : one fetch queue entry {pc4, inst}
package mips_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP = 32'h0000_0000;

  // IDLE : no request outstanding
  // BUSY : live request outstanding, its data will be queued
  // DRAIN: stale request outstanding (redirected), its data will be dropped
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry fetch queue. Entry 0 is the head (drives IF/ID), entry 1 is the skid.
// Ports:
//   clk, rst    : clock, asynchronous active-low reset
//   clear       : drop all entries (wins over push/pop)
//   push        : write push_data behind whatever survives this edge's pop
//   push_data   : entry to write
//   pop         : remove the head; the skid entry moves up
//   head        : current head entry (meaningful when count != 0)
//   count       : occupancy, 0..2
module fetch_skid_buf
  import mips_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [1:0]   count
);

  fetch_entry_t e0, e1;
  logic         pop_eff;
  logic [1:0]   base;

  // A pop on an empty queue is ignored; base is the occupancy left after the pop,
  // which is also the slot index a push lands in.
  assign pop_eff = pop && (count != 2'd0);
  assign base    = count - {1'b0, pop_eff};
  assign head    = e0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 2'd0;
      e0    <= '0;
      e1    <= '0;
    end else if (clear) begin
      count <= 2'd0;
    end else begin
      if (pop_eff && count == 2'd2) e0 <= e1;
      if (push) begin
        if (base == 2'd0) e0 <= push_data;
        else              e1 <= push_data;
      end
      count <= base + {1'b0, push};
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage, producer side of the IF/ID register.
// Ports:
//   clk, rst               : clock, asynchronous active-low reset
//   stall                  : IF/ID not capturing; head entry held
//   redirect, redirect_pc  : flush queue and refetch from redirect_pc
//   imem_req, imem_addr    : registered memory request / address
//   imem_ack, imem_rdata   : request completion and returned word
//   PC4, inst, valid       : head entry presented to IF/ID (zeros when invalid)
//   fsm_state              : current fetch FSM state, for observation
// Handshake: imem_req rises with imem_addr and both stay constant until an edge
// that samples imem_ack=1; that edge completes the transfer and drops imem_req.
// A request is never withdrawn early, so a redirected request is drained (DRAIN)
// and its data discarded.
module if_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] PC4,
  output logic [DATA_W-1:0] inst,
  output logic              valid,
  output fetch_state_e      fsm_state
);

  fetch_state_e      state, state_d;
  logic [ADDR_W-1:0] pc, pc_d, addr_d;
  logic              req_d;

  fetch_entry_t q_head, q_push_data;
  logic [1:0]   q_count, occ_after;
  logic         q_push, q_pop, consume;

  fetch_skid_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .head      (q_head),
    .count     (q_count)
  );

  assign valid       = (q_count != 2'd0);
  assign consume     = valid && !stall;
  assign q_pop       = consume;
  // Occupancy once this edge's consume is taken into account; issuing only when
  // this is <= 1 guarantees the returning word always has a free slot.
  assign occ_after   = q_count - {1'b0, consume};
  assign q_push_data = '{pc4: imem_addr + ADDR_W'(4), inst: imem_rdata};

  assign PC4       = valid ? q_head.pc4  : '0;
  assign inst      = valid ? q_head.inst : NOP;
  assign fsm_state = state;

  always_comb begin
    state_d = state;
    pc_d    = pc;
    req_d   = imem_req;
    addr_d  = imem_addr;
    q_push  = 1'b0;
    unique case (state)
      IDLE: begin
        if (redirect) begin
          pc_d = redirect_pc;
        end else if (occ_after <= 2'd1) begin
          req_d   = 1'b1;
          addr_d  = pc;
          pc_d    = pc + ADDR_W'(4);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (imem_ack) begin
          req_d   = 1'b0;
          q_push  = !redirect;
          state_d = IDLE;
        end else if (redirect) begin
          state_d = DRAIN;
        end
        if (redirect) pc_d = redirect_pc;
      end
      DRAIN: begin
        if (redirect) pc_d = redirect_pc;
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      pc        <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      imem_req  <= req_d;
      imem_addr <= addr_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
  import mips_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] PC4;
  logic [31:0] inst;
  logic        valid;
  fetch_state_e fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  int mem_lat  = 1;
  int mem_cnt  = 0;

  if_fetch_unit #(.RESET_PC(32'h0), .ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .PC4         (PC4),
    .inst        (inst),
    .valid       (valid),
    .fsm_state   (fsm_state)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // A push must always find a free slot.
  always @(negedge clk) begin
    if (rst && dut.q_push) begin
      n_checks++;
      assert (!(dut.q_count == 2'd2 && !dut.q_pop)) else begin
        n_fail++;
        $error("FAIL overflow: observed count %0d with push and no pop, expected < 2", dut.q_count);
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One clock; afterwards the memory model updates ack/rdata for the new cycle.
  // Memory word at address A is 32'hC0DE_0000 + A.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!imem_req) begin
      mem_cnt  = 0;
      imem_ack = 1'b0;
    end else begin
      mem_cnt++;
      imem_ack   = (mem_cnt >= mem_lat);
      imem_rdata = imem_ack ? (32'hC0DE_0000 + imem_addr) : 32'hDEAD_BEEF;
    end
  endtask

  task automatic do_reset();
    rst      = 1'b0;
    imem_ack = 1'b0;
    mem_cnt  = 0;
    stall    = 1'b0;
    redirect = 1'b0;
    #1;
    chk("rst_req",   imem_req,  32'h0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", valid,     32'h0);
    chk("rst_inst",  inst,      32'h0);
    chk("rst_pc4",   PC4,       32'h0);
    chk("rst_state", 32'(fsm_state), 32'(IDLE));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_valid(input int max_cycles, input string tag);
    int k;
    k = 0;
    while (!valid && k < max_cycles) begin
      tick();
      k++;
    end
    chk(tag, valid, 32'h1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    #1;
    // Streaming fetch, 1-cycle memory
    do_reset();
    mem_lat = 1;
    tick(); chk("t1_req0", imem_req, 32'h1); chk("t1_addr0", imem_addr, 32'h0); chk("t1_nv0", valid, 32'h0);
    tick(); chk("t1_v1", valid, 32'h1); chk("t1_pc4_4", PC4, 32'h4); chk("t1_inst_4", inst, 32'hC0DE_0000);
    chk("t1_req_lo", imem_req, 32'h0);
    tick(); chk("t1_nv1", valid, 32'h0); chk("t1_addr4", imem_addr, 32'h4);
    tick(); chk("t1_pc4_8", PC4, 32'h8); chk("t1_inst_8", inst, 32'hC0DE_0004);
    tick(); chk("t1_addr8", imem_addr, 32'h8);
    tick(); chk("t1_pc4_12", PC4, 32'hC); chk("t1_inst_12", inst, 32'hC0DE_0008);

    // Stall for 5 cycles after first valid
    do_reset();
    tick(); tick(); chk("t2_pc4_4", PC4, 32'h4);
    stall = 1'b1;
    tick(); chk("t2_req", imem_req, 32'h1); chk("t2_addr4", imem_addr, 32'h4); chk("t2_hold_a", PC4, 32'h4);
    tick(); chk("t2_req_lo", imem_req, 32'h0); chk("t2_hold_b", PC4, 32'h4);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("t2_noreq", imem_req, 32'h0); chk("t2_hold", PC4, 32'h4); chk("t2_hold_v", valid, 32'h1);
    end
    stall = 1'b0;
    tick(); chk("t2_pc4_8", PC4, 32'h8); chk("t2_inst_8", inst, 32'hC0DE_0004); chk("t2_addr8", imem_addr, 32'h8);
    tick(); chk("t2_pc4_12", PC4, 32'hC); chk("t2_inst_12", inst, 32'hC0DE_0008);

    // Latency 4, redirect while a request is waiting
    do_reset();
    mem_lat = 4;
    tick(); chk("t3_addr0", imem_addr, 32'h0);
    tick(); tick(); tick();
    tick(); chk("t3_pc4_4", PC4, 32'h4); chk("t3_inst_4", inst, 32'hC0DE_0000);
    stall = 1'b1;
    tick(); chk("t3_req", imem_req, 32'h1); chk("t3_addr4", imem_addr, 32'h4);
    tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0; stall = 1'b0;
    chk("t3_flush", valid, 32'h0); chk("t3_req_held", imem_req, 32'h1); chk("t3_addr_held", imem_addr, 32'h4);
    chk("t3_drain", 32'(fsm_state), 32'(DRAIN));
    tick(); chk("t3_req_held2", imem_req, 32'h1); chk("t3_addr_held2", imem_addr, 32'h4);
    tick(); chk("t3_req_drop", imem_req, 32'h0); chk("t3_nv", valid, 32'h0); chk("t3_idle", 32'(fsm_state), 32'(IDLE));
    tick(); chk("t3_addr100", imem_addr, 32'h100); chk("t3_req100", imem_req, 32'h1);
    wait_valid(12, "t3_wait");
    chk("t3_pc4_104", PC4, 32'h104); chk("t3_inst_100", inst, 32'hC0DE_0100);

    // Redirect on the same edge as ack
    do_reset();
    mem_lat = 1;
    tick();
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect = 1'b0;
    chk("t4_nv", valid, 32'h0); chk("t4_req_lo", imem_req, 32'h0); chk("t4_inst0", inst, 32'h0);
    tick(); chk("t4_addr200", imem_addr, 32'h200); chk("t4_req", imem_req, 32'h1);
    tick(); chk("t4_pc4", PC4, 32'h204); chk("t4_inst", inst, 32'hC0DE_0200);

    // Redirect while stalled with both entries full
    do_reset();
    tick(); tick();
    stall = 1'b1;
    tick(); tick();
    chk("t5_full", 32'(dut.q_count), 32'h2); chk("t5_req_lo", imem_req, 32'h0); chk("t5_head", PC4, 32'h4);
    redirect = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect = 1'b0;
    chk("t5_nv", valid, 32'h0); chk("t5_inst0", inst, 32'h0); chk("t5_pc4_0", PC4, 32'h0);
    tick(); chk("t5_addr300", imem_addr, 32'h300); chk("t5_req", imem_req, 32'h1);
    tick(); chk("t5_pc4", PC4, 32'h304); chk("t5_inst", inst, 32'hC0DE_0300);
    tick(); chk("t5_hold", PC4, 32'h304); chk("t5_addr304", imem_addr, 32'h304);
    stall = 1'b0;

    // PC wrap at the top of the address space
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    chk("t7_noreq", imem_req, 32'h0);
    tick(); chk("t7_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick(); chk("t7_pc4_wrap", PC4, 32'h0); chk("t7_inst", inst, 32'hC0DD_FFFC); chk("t7_v", valid, 32'h1);
    tick(); chk("t7_addr_wrap", imem_addr, 32'h0);

    // Asynchronous reset while BUSY with a valid head
    do_reset();
    mem_lat = 4;
    tick(); tick(); tick(); tick(); tick();
    chk("t6_v", valid, 32'h1);
    stall = 1'b1;
    tick(); chk("t6_busy", 32'(fsm_state), 32'(BUSY));
    #2;
    rst = 1'b0;
    #1;
    chk("t6_req", imem_req, 32'h0); chk("t6_valid", valid, 32'h0);
    chk("t6_inst", inst, 32'h0); chk("t6_pc4", PC4, 32'h0); chk("t6_addr", imem_addr, 32'h0);
    stall = 1'b0; mem_lat = 1; imem_ack = 1'b0; mem_cnt = 0;
    @(negedge clk);
    rst = 1'b1;
    tick(); chk("t6_req_rp", imem_req, 32'h1); chk("t6_addr_rp", imem_addr, 32'h0);
    tick(); chk("t6_pc4_4", PC4, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no end of test, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage; producer side of the IF/ID pipeline register.
- Issues instruction-memory requests over a req/ack handshake with variable latency.
- Buffers returned words in a 2-entry queue and presents {PC4, inst, valid} to IF/ID.
- Obeys the hazard unit's stall and the branch unit's redirect (flush), so IF/ID can capture on every non-stalled edge.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- ADDR_W, 32, PC / memory address width.
- DATA_W, 32, instruction width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low.
- stall  in  1  IF/ID not writing this cycle; the head entry is held.
- redirect  in  1  branch/jump taken; flush and refetch from redirect_pc.
- redirect_pc  in  ADDR_W  new fetch address, word-aligned.
- imem_req  out  1  registered memory request, held until acknowledged.
- imem_addr  out  ADDR_W  registered request address, stable while imem_req=1.
- imem_ack  in  1  request complete; imem_rdata valid this cycle; only meaningful while imem_req=1.
- imem_rdata  in  DATA_W  instruction word.
- PC4  out  ADDR_W  head entry's address+4; 0 when valid=0.
- inst  out  DATA_W  head entry's instruction; 0 (NOP) when valid=0.
- valid  out  1  head entry present.

Behaviour:
- Reset (rst=0, async):
  - pc=RESET_PC; queue empty; kill=0; imem_req=0; imem_addr=0.
  - valid=0, inst=0, PC4=0.
- Internal state:
  - pc = next address to request.
  - Queue of 2 entries {pc4, inst}: head drives the outputs, second entry is the skid.
  - kill = flag marking the outstanding request as stale.
- FSM states:
  - IDLE: no outstanding request.
  - BUSY: live request outstanding.
  - DRAIN: killed request outstanding.
- Issue rule (IDLE only): if queue occupancy after this edge will be ≤1, then at the edge set imem_req←1, imem_addr←pc, pc←pc+4, go to BUSY.
  - Occupancy counts the head as consumed if valid && !stall.
  - Throughput is therefore at most one request per 2 cycles (IDLE→BUSY→IDLE). This is accepted.
- BUSY with imem_ack=1:
  - imem_req←0; push {imem_addr+4, imem_rdata}; go to IDLE.
  - The entry goes to head if the head is empty or consumed this edge, else to the skid.
  - Overflow is impossible by the issue rule. The bench asserts this.
- Consume: at an edge with valid && !stall, the head is popped and the skid advances to head.
- Redirect (highest priority, overrides stall and ack):
  - Queue cleared, so valid=0 after the edge.
  - pc←redirect_pc.
  - If in BUSY without ack: go to DRAIN. imem_req and imem_addr stay unchanged; the protocol forbids withdrawing a request.
  - If ack arrives the same edge: data is discarded, imem_req←0, go to IDLE.
  - In IDLE: stays IDLE; the new request issues at the next edge.
- DRAIN with imem_ack=1: data dropped, imem_req←0, go to IDLE.
  - A further redirect during DRAIN only updates pc.
- Stall and redirect together: redirect wins.
- Stall with valid=0: no effect.
- Outputs are registered/queue-driven, with no combinational path from imem_rdata to inst.
- PC arithmetic: modulo 2^ADDR_W; 32'hFFFF_FFFC+4 wraps to 0.
- Reset mid-operation: abandons any outstanding request immediately (imem_req=0). The memory model must tolerate a dropped request.

Decomposition:
- Shared package mips_pkg: NOP encoding (32'h0), fetch FSM state enum {IDLE, BUSY, DRAIN}, queue entry struct {pc4, inst}.
- One natural sub-module: fetch_skid_buf, a 2-entry queue with push, pop, clear, head outputs and occupancy.
- The FSM, pc register and request logic stay in the top level.

Test Plan:
- Reset, then release with 1-cycle-ack memory and stall=0 → imem_addr sequence 0,4,8,…; outputs valid with PC4=4,8,12 and the matching inst, one new head every 2 cycles.
- Hold stall=1 for 5 cycles after the first valid (PC4=4) → head stays PC4=4. At most one more request completes into the skid, then imem_req stays 0. On release, PC4=4 is consumed, then PC4=8 is presented.
- Memory latency 4, redirect to 32'h100 on the 2nd wait cycle → valid=0 next edge, imem_req held with the old address until ack, that data is dropped, next imem_addr=32'h100, first valid PC4=32'h104.
- Redirect on the same edge as imem_ack → returned word never appears on inst, next request address = redirect_pc.
- Redirect while stall=1 and both entries full → both entries discarded, valid=0, fetch resumes from redirect_pc.
- Assert rst=0 asynchronously mid-BUSY → imem_req, valid, inst and PC4 drop to 0 without a clock edge. After release, the first request uses RESET_PC.
